// File: rtl/jk_bank_driver_pkg.sv
// Shared types and constants for the JK bank driver: FSM states, excitation codes, settle limit.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } drv_state_e;

    // Excitation codes are {J, K}.
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] CLR  = 2'b01;
    localparam logic [1:0] TGL  = 2'b11;

    localparam int SETTLE_MAX = 15;

    function automatic logic [1:0] excite(input logic cur, input logic tgt,
                                          input logic mask, input logic toggle);
        logic [1:0] code;
        code = HOLD;
        if (mask && (cur != tgt)) begin
            if (toggle) code = TGL;
            else        code = tgt ? SET : CLR;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request handshake bundle for the JK bank driver: target pattern plus drive-mode flags.
interface jk_bank_driver_if #(
    parameter int WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic             req_serial;
    logic             req_toggle;

    modport master (
        output req_valid, req_target, req_serial, req_toggle,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_target, req_serial, req_toggle,
        output req_ready
    );
endinterface

// File: rtl/jk_bank_driver_excite_enc.sv
// Combinational per-bit JK excitation encoder; only masked bits that differ from cur are driven.
module jk_excite_enc
    import jk_drv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] tgt_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             toggle_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);
    always_comb begin
        j_o = '0;
        k_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_o[i], k_o[i]} = excite(cur_i[i], tgt_i[i], mask_i[i], toggle_i);
        end
    end
endmodule

// File: rtl/jk_bank_driver.sv
// JK flip-flop bank driver: moves the bank from its shadowed state to a requested target.
// Optional macro JK_CHECK_EN adds q_obs/mismatch to compare the observed bank at completion.
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_driver_if.slave  req,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
`ifdef JK_CHECK_EN
    ,
    input  logic [WIDTH-1:0] q_obs,
    output logic             mismatch
`endif
);
    localparam int         SETTLE_EFF  = (SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYC;
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_EFF > 0) ? 4'(SETTLE_EFF - 1) : 4'd0;

    drv_state_e       state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] target_q;
    logic             serial_q;
    logic             toggle_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;
`ifdef JK_CHECK_EN
    logic             mismatch_q;
`endif

    logic [WIDTH-1:0] rem_acc, lsb_acc, lsb_cur, rem_d, lsb_d;
    logic [WIDTH-1:0] enc_tgt, enc_mask, enc_j, enc_k;
    logic             enc_tgl;

    // In IDLE the encoder prepares the first drive from the incoming request;
    // in DRIVE it prepares the following serial step (nothing for parallel).
    always_comb begin
        rem_acc  = req.req_target ^ shadow_q;
        lsb_acc  = rem_acc & (~rem_acc + WIDTH'(1));
        lsb_cur  = rem_q & (~rem_q + WIDTH'(1));
        rem_d    = serial_q ? (rem_q & ~lsb_cur) : '0;
        lsb_d    = rem_d & (~rem_d + WIDTH'(1));
        enc_tgt  = target_q;
        enc_mask = lsb_d;
        enc_tgl  = toggle_q;
        if (state_q == IDLE) begin
            enc_tgt  = req.req_target;
            enc_mask = req.req_serial ? lsb_acc : rem_acc;
            enc_tgl  = req.req_toggle;
        end
    end

    jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
        .cur_i    (shadow_q),
        .tgt_i    (enc_tgt),
        .mask_i   (enc_mask),
        .toggle_i (enc_tgl),
        .j_o      (enc_j),
        .k_o      (enc_k)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            target_q   <= '0;
            serial_q   <= 1'b0;
            toggle_q   <= 1'b0;
            cnt_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            shadow_q   <= '0;
`ifdef JK_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            j_q    <= '0;
            k_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (req.req_valid && ready_q) begin
                        target_q <= req.req_target;
                        serial_q <= req.req_serial;
                        toggle_q <= req.req_toggle;
                        rem_q    <= rem_acc;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        if (rem_acc == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE;
                            j_q     <= enc_j;
                            k_q     <= enc_k;
                        end
                    end
                end
                DRIVE: begin
                    shadow_q <= serial_q ? (shadow_q ^ lsb_cur) : target_q;
                    rem_q    <= rem_d;
                    if (rem_d != '0) begin
                        j_q <= enc_j;
                        k_q <= enc_k;
                    end else if (SETTLE_EFF > 0) begin
                        state_q <= SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
`ifdef JK_CHECK_EN
                    if (q_obs != shadow_q) mismatch_q <= 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready = ready_q;
    assign j_out         = j_q;
    assign k_out         = k_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef JK_CHECK_EN
    assign mismatch      = mismatch_q;
`endif

endmodule
